// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus cycle sequencer (wait states, SDRAM handshake, DTACK/BERR).
// Optional bus timeout / BERR generation enabled by defining BUS_TIMEOUT_EN.
module bus_cycle_ctrl #(
    parameter int LOCAL_WAIT = 2,
    parameter int SOUND_WAIT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_as_n,
    input  logic [1:0] cpu_ds_n,
    input  logic       ROMn,
    input  logic       WORKn,
    input  logic       SOUNDn,
    input  logic       SCREENn,
    input  logic       OBJECTn,
    input  logic       COLORn,
    input  logic       IO0n,
    input  logic       IO1n,
    input  logic       PRIORITYn,
    input  logic       EXTENSIONn,
    input  logic       sdr_ack,
    output logic       sdr_req,
    output logic       sdr_sel,
    output logic       cpu_dtack_n,
    output logic       cpu_berr_n,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SDR,
        WAIT,
        ACK,
        BERR,
        DRAIN
    } state_t;

`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] LW       = 8'(LOCAL_WAIT);
    localparam logic [7:0] SW       = 8'(SOUND_WAIT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tmo_q, tmo_d;
    logic       sel_q, sel_d;
    logic       unmap_q, unmap_d;
    logic       pend_q, pend_d;
    logic       req_q, dtack_n_q, busy_q;

    logic start;
    logic local_any;
    logic tmo_hit;

    assign start     = ~cpu_as_n & ~(&cpu_ds_n);
    assign local_any = ~(SCREENn & OBJECTn & COLORn & IO0n
                         & IO1n & PRIORITYn & EXTENSIONn);
    assign tmo_hit   = TMO_EN && (tmo_q == TMO_LAST);

    // Next-state decode: region classification, wait count, handshake and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        sel_d   = sel_q;
        unmap_d = unmap_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tmo_d   = '0;
                    unmap_d = 1'b0;
                    pend_d  = 1'b0;
                    if (!ROMn) begin
                        state_d = SDR;
                        sel_d   = 1'b0;
                        pend_d  = 1'b1;
                    end else if (!WORKn) begin
                        state_d = SDR;
                        sel_d   = 1'b1;
                        pend_d  = 1'b1;
                    end else if (!SOUNDn) begin
                        state_d = WAIT;
                        cnt_d   = SW;
                    end else if (local_any) begin
                        state_d = WAIT;
                        cnt_d   = LW;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LW;
                        unmap_d = TMO_EN;
                    end
                end
            end
            WAIT: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end else if (unmap_q) begin
                    if (tmo_hit) state_d = BERR;
                    else tmo_d = tmo_q + 8'd1;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SDR: begin
                if (sdr_ack) begin
                    pend_d  = 1'b0;
                    state_d = cpu_as_n ? IDLE : ACK;
                end else if (cpu_as_n) begin
                    state_d = DRAIN;
                end else if (tmo_hit) begin
                    state_d = BERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ACK: begin
                if (cpu_as_n) state_d = IDLE;
            end
            BERR: begin
                if (sdr_ack) pend_d = 1'b0;
                if (cpu_as_n) begin
                    state_d = (pend_q && !sdr_ack) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (sdr_ack) begin
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and outputs, all registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            sel_q     <= 1'b0;
            unmap_q   <= 1'b0;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            dtack_n_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            sel_q     <= sel_d;
            unmap_q   <= unmap_d;
            pend_q    <= pend_d;
            req_q     <= (state_d == SDR) || (state_d == DRAIN)
                         || ((state_d == BERR) && pend_d);
            dtack_n_q <= (state_d != ACK);
            busy_q    <= (state_d != IDLE);
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic berr_n_q;

    // Bus error strobe, asserted while the sequencer sits in BERR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) berr_n_q <= 1'b1;
        else          berr_n_q <= (state_d != BERR);
    end

    assign cpu_berr_n = berr_n_q;
`else
    assign cpu_berr_n = 1'b1;
`endif

    assign sdr_req     = req_q;
    assign sdr_sel     = sel_q;
    assign cpu_dtack_n = dtack_n_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed scoreboard bench for bus_cycle_ctrl.
// Stimulus queues expected output edges; a negedge monitor pops and compares.
module tb_bus_cycle_ctrl;

    localparam int EV_REQ0 = 0;
    localparam int EV_REQ1 = 1;
    localparam int EV_REQF = 2;
    localparam int EV_DTF  = 3;
    localparam int EV_DTR  = 4;
    localparam int EV_BEF  = 5;
    localparam int EV_BER  = 6;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cpu_as_n;
    logic [1:0] cpu_ds_n;
    logic       ROMn, WORKn, SOUNDn;
    logic       SCREENn, OBJECTn, COLORn, IO0n, IO1n, PRIORITYn, EXTENSIONn;
    logic       sdr_ack;
    logic       sdr_req, sdr_sel, cpu_dtack_n, cpu_berr_n, busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    ev_t  expq[$];
    logic p_req, p_dt, p_be;

    bus_cycle_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_as_n   (cpu_as_n),
        .cpu_ds_n   (cpu_ds_n),
        .ROMn       (ROMn),
        .WORKn      (WORKn),
        .SOUNDn     (SOUNDn),
        .SCREENn    (SCREENn),
        .OBJECTn    (OBJECTn),
        .COLORn     (COLORn),
        .IO0n       (IO0n),
        .IO1n       (IO1n),
        .PRIORITYn  (PRIORITYn),
        .EXTENSIONn (EXTENSIONn),
        .sdr_ack    (sdr_ack),
        .sdr_req    (sdr_req),
        .sdr_sel    (sdr_sel),
        .cpu_dtack_n(cpu_dtack_n),
        .cpu_berr_n (cpu_berr_n),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    task automatic got(input int k);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d required none", k, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                failures++;
                $display("FAIL event got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                         k, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Output-edge monitor feeding the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!p_req && sdr_req) got(sdr_sel ? EV_REQ1 : EV_REQ0);
            if (p_req && !sdr_req) got(EV_REQF);
            if (p_dt && !cpu_dtack_n) got(EV_DTF);
            if (!p_dt && cpu_dtack_n) got(EV_DTR);
            if (p_be && !cpu_berr_n) got(EV_BEF);
            if (!p_be && cpu_berr_n) got(EV_BER);
        end
        p_req = sdr_req;
        p_dt  = cpu_dtack_n;
        p_be  = cpu_berr_n;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic idle_in();
        cpu_as_n   = 1'b1;
        cpu_ds_n   = 2'b11;
        ROMn       = 1'b1;
        WORKn      = 1'b1;
        SOUNDn     = 1'b1;
        SCREENn    = 1'b1;
        OBJECTn    = 1'b1;
        COLORn     = 1'b1;
        IO0n       = 1'b1;
        IO1n       = 1'b1;
        PRIORITYn  = 1'b1;
        EXTENSIONn = 1'b1;
        sdr_ack    = 1'b0;
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic outs_reset(input string nm);
        chk({nm, "_dtack"}, {7'd0, cpu_dtack_n}, 8'd1);
        chk({nm, "_berr"},  {7'd0, cpu_berr_n},  8'd1);
        chk({nm, "_req"},   {7'd0, sdr_req},     8'd0);
        chk({nm, "_sel"},   {7'd0, sdr_sel},     8'd0);
        chk({nm, "_busy"},  {7'd0, busy},        8'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        reset_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        SCREENn  = 1'b0;
        @(negedge clk);
        outs_reset("rst_hold");

        // Local access straight out of reset.
        reset_n = 1'b1;
        mon_en  = 1'b1;
        n = cyc + 1;
        push(EV_DTF, n + 3);
        at(n + 5);
        idle_in();
        push(EV_DTR, n + 6);

        // Sound beats color; back-to-back start right after IDLE.
        at(n + 6);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b10;
        SOUNDn   = 1'b0;
        COLORn   = 1'b0;
        push(EV_DTF, n + 5);
        at(n + 6);
        idle_in();
        push(EV_DTR, n + 7);

        // ROM, ack seven cycles after start; selects change mid-cycle.
        at(n + 7);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b01;
        ROMn     = 1'b0;
        push(EV_REQ0, n);
        at(n + 1);
        ROMn  = 1'b1;
        WORKn = 1'b0;
        at(n + 3);
        chk("rom_sel_latched", {7'd0, sdr_sel}, 8'd0);
        chk("rom_busy", {7'd0, busy}, 8'd1);
        m = n + 7;
        at(m - 1);
        sdr_ack = 1'b1;
        push(EV_REQF, m);
        push(EV_DTF, m);
        at(m);
        sdr_ack = 1'b0;
        at(m + 1);
        idle_in();
        push(EV_DTR, m + 2);

        // Work RAM, ack three cycles after start.
        at(m + 3);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        WORKn    = 1'b1;
        WORKn    = 1'b0;
        push(EV_REQ1, n);
        m = n + 3;
        at(m - 1);
        sdr_ack = 1'b1;
        push(EV_REQF, m);
        push(EV_DTF, m);
        at(m);
        sdr_ack = 1'b0;
        idle_in();
        push(EV_DTR, m + 1);

        // ROM with strobe released before ack: drain, no DTACK.
        at(m + 2);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        ROMn     = 1'b0;
        push(EV_REQ0, n);
        at(n + 2);
        idle_in();
        at(n + 4);
        chk("drain_busy", {7'd0, busy}, 8'd1);
        chk("drain_req", {7'd0, sdr_req}, 8'd1);
        at(n + 5);
        sdr_ack = 1'b1;
        push(EV_REQF, n + 6);
        at(n + 6);
        sdr_ack = 1'b0;
        chk("drain_done_busy", {7'd0, busy}, 8'd0);

        // Ack coincident with strobe release: no DTACK.
        at(n + 7);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        WORKn    = 1'b0;
        push(EV_REQ1, n);
        at(n + 3);
        idle_in();
        sdr_ack = 1'b1;
        push(EV_REQF, n + 4);
        at(n + 4);
        sdr_ack = 1'b0;
        chk("coinc_busy", {7'd0, busy}, 8'd0);

        // Address strobe without data strobes starts nothing.
        at(n + 5);
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b11;
        ROMn     = 1'b0;
        n = cyc;
        at(n + 4);
        chk("nods_busy", {7'd0, busy}, 8'd0);
        chk("nods_req", {7'd0, sdr_req}, 8'd0);
        idle_in();

        // Unmapped access.
        at(n + 5);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
`ifdef BUS_TIMEOUT_EN
        push(EV_BEF, n + 255);
        at(n + 256);
        idle_in();
        push(EV_BER, n + 257);
        at(n + 257);
`else
        push(EV_DTF, n + 3);
        at(n + 4);
        idle_in();
        push(EV_DTR, n + 5);
        at(n + 5);
`endif

        // Sound access aborted in WAIT: no DTACK.
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        SOUNDn   = 1'b0;
        at(n + 2);
        idle_in();
        at(n + 4);
        chk("abort_busy", {7'd0, busy}, 8'd0);

        // Reset while sdr_req is high.
        at(n + 5);
        n = cyc + 1;
        cpu_as_n = 1'b0;
        cpu_ds_n = 2'b00;
        ROMn     = 1'b0;
        push(EV_REQ0, n);
        at(n + 2);
        #2;
        reset_n = 1'b0;
        #1;
        outs_reset("rst_mid");
        push(EV_REQF, cyc + 1);
        idle_in();
        @(negedge clk);
        reset_n = 1'b1;

        at(cyc + 10);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
